// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch/decode pipeline types and constants
package fetch_queue_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  // One fetched instruction with its address; decode consumes the same layout.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } if_entry;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side and decode-side handshake bundle of the fetch queue
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int AW = 2
);

  logic              in_valid;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_instr;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_instr;
  logic              out_ready;
  logic [AW:0]       count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/fetch_queue_ptr_ctrl.sv
// rtl/fetch_queue_ptr_ctrl.sv - fetch queue pointer and occupancy bookkeeping (fq_ptr_ctrl)
module fq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic push_ok;
  logic pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Guarding here keeps count inside 0..DEPTH whatever the caller does.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue; FETCH_QUEUE_BYPASS_EN enables empty-queue pass-through
module fetch_queue
  import fetch_queue_pkg::WORD_W;
  import fetch_queue_pkg::if_entry;
#(
  parameter int                DEPTH     = 4,
  parameter int                AW        = 2,
  parameter logic [WORD_W-1:0] NOP_INSTR = fetch_queue_pkg::NOP_INSTR
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave bus
);

  if_entry       mem [DEPTH];
  if_entry       head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  fq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptr_ctrl (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (bus.flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign head = mem[rd_ptr];

  always_comb begin
    push          = bus.in_valid & ~full;
    pop           = ~empty & bus.out_ready;
    bus.out_valid = ~empty;
    bus.out_pc    = empty ? '0 : head.pc;
    bus.out_instr = empty ? NOP_INSTR : head.instr;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: hand the fetch word straight to decode; store it only if decode stalls.
    if (empty && bus.in_valid && !bus.flush) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = bus.in_pc;
      bus.out_instr = bus.in_instr;
      if (bus.out_ready) push = 1'b0;
    end
`endif
  end

  assign bus.in_ready = ~full;
  assign bus.count    = count;

  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fetch_queue_if #(.AW(2)) bus ();

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = instr_of(pc);
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int mc;
    int pushed;
    int popped;
    logic iv;
    logic ordy;
    logic do_push;
    logic do_pop;

    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) step();
    chk("rst_count", bus.count, 3'd0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    reset = 1'b0;
    step();

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_count_before", bus.count, 3'd3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", bus.count, 3'd0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_out_instr", bus.out_instr, 32'h0);
    #1 reset = 1'b0;
    step();

    // fill then drain
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    chk("fill_count", bus.count, 3'd4);
    chk("fill_in_ready", bus.in_ready, 1'b0);
    set_in(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    chk("fill_fifth_count", bus.count, 3'd4);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("drain_valid", bus.out_valid, 1'b1);
      chk("drain_pc", bus.out_pc, 32'(4 * i));
      chk("drain_instr", bus.out_instr, instr_of(32'(4 * i)));
      step();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("drain_empty_valid", bus.out_valid, 1'b0);
    chk("drain_empty_instr", bus.out_instr, 32'h0);
    chk("drain_empty_count", bus.count, 3'd0);
    step();

    // wrap-around with out_ready toggling against a reference model
    mc = 0;
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 40 && popped < 10; i++) begin
      iv   = (pushed < 10);
      ordy = i[0];
      set_in(iv, 32'h200 + 32'(4 * pushed), ordy, 1'b0);
      #1;
      chk("wrap_count", bus.count, 64'(mc));
      chk("wrap_in_ready", bus.in_ready, (mc != 4));
      chk("wrap_out_valid", bus.out_valid, (mc != 0));
      do_push = iv && (mc != 4);
      do_pop  = ordy && (mc != 0);
      if (do_pop) begin
        chk("wrap_out_pc", bus.out_pc, exp_q[0]);
        void'(exp_q.pop_front());
        popped++;
        mc--;
      end
      if (do_push) begin
        exp_q.push_back(32'h200 + 32'(4 * pushed));
        pushed++;
        mc++;
      end
      step();
    end
    chk("wrap_all_popped", 64'(popped), 64'd10);
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    step();

    // full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    set_in(1'b1, 32'h310, 1'b1, 1'b0);
    #1;
    chk("fullpop_in_ready", bus.in_ready, 1'b0);
    chk("fullpop_head", bus.out_pc, 32'h300);
    step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("fullpop_count", bus.count, 3'd3);
    chk("fullpop_in_ready_after", bus.in_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("fullpop_drain_pc", bus.out_pc, 32'h300 + 32'(4 * i));
      step();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("fullpop_no_extra", bus.out_valid, 1'b0);
    step();

    // flush priority
    set_in(1'b1, 32'h400, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h404, 1'b0, 1'b0);
    step();
    chk("flush_pre_count", bus.count, 3'd2);
    set_in(1'b1, 32'h40, 1'b1, 1'b1);
    step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("flush_count", bus.count, 3'd0);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_out_instr", bus.out_instr, 32'h0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    step();
    set_in(1'b1, 32'h80, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("flush_next_count", bus.count, 3'd1);
    chk("flush_next_head", bus.out_pc, 32'h80);
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    step();

    // empty-queue pass-through (or one-cycle latency without it)
    set_in(1'b1, 32'h20, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_out_valid", bus.out_valid, 1'b1);
    chk("bypass_out_pc", bus.out_pc, 32'h20);
    chk("bypass_out_instr", bus.out_instr, instr_of(32'h20));
`else
    chk("nobypass_out_valid", bus.out_valid, 1'b0);
    chk("nobypass_out_pc", bus.out_pc, 32'h0);
`endif
    step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_count", bus.count, 3'd0);
    chk("bypass_after_valid", bus.out_valid, 1'b0);
`else
    chk("nobypass_count", bus.count, 3'd1);
    chk("nobypass_after_valid", bus.out_valid, 1'b1);
    chk("nobypass_after_pc", bus.out_pc, 32'h20);
`endif
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("final_empty", bus.count, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction queue directly downstream of the fetch stage (PC-addressed instruction SRAM read) and upstream of decode.
- Captures {PC, instruction} pairs from fetch and presents them to decode with a valid/ready handshake.
- Backpressures the PC update via in_ready.
- Flushes all entries on a control-flow redirect so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).
- NOP_INSTR, 32'h0000_0000, value driven on out_instr when the queue is empty.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_pc  input  32  PC of the presented instruction.
- in_instr  input  32  instruction word from the fetch SRAM.
- in_ready  output  1  queue can accept; the PC register may advance only when in_valid and in_ready are both high.
- flush  input  1  redirect (branch/jump taken); discard all contents.
- out_valid  output  1  head entry valid for decode.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry; NOP_INSTR when empty.
- out_ready  input  1  decode accepts the head this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry circular buffer of {pc, instr}.
  - wr_ptr and rd_ptr are AW bits and wrap naturally from DEPTH-1 to 0.
  - count is a registered AW+1-bit occupancy counter.
- Reset (async, any time, including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR.
  - Storage contents need not be cleared.
- in_ready = (count != DEPTH). It is purely registered-state-derived, with no combinational path from out_ready.
- push = in_valid & in_ready. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = out_valid & out_ready. On pop, rd_ptr increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full (count==DEPTH):
  - in_ready=0, so no push occurs even if a pop happens in the same cycle.
  - in_ready returns high the cycle after the pop.
- Empty (count==0):
  - out_valid=0, out_instr=NOP_INSTR, out_pc=0.
  - out_ready is ignored.
- out_valid = (count != 0). out_pc and out_instr are a combinational read of the entry at rd_ptr.
- Latency: a push in cycle N appears at the head no earlier than cycle N+1. Order is strictly FIFO.
- flush (synchronous, highest priority):
  - Next edge: wr_ptr=0, rd_ptr=0, count=0.
  - Any same-cycle push or pop is discarded.
  - in_ready stays asserted unless the queue is full. A push accepted during the flush cycle is dropped; fetch must redirect its PC in the same cycle.
- flush on an empty queue has no effect beyond resetting the pointers.
- count never exceeds DEPTH and never underflows. Illegal states are unreachable by construction.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, in_valid=1 and flush=0: out_valid=1 combinationally, out_pc=in_pc, out_instr=in_instr.
  - If out_ready=1 in that cycle, the entry is consumed without being written (zero-latency pass-through; pointers and count unchanged).
  - If out_ready=0, it is written normally.
- Undefined:
  - Minimum latency is 1 cycle.
  - Outputs are a function of registered state only.

Decomposition:
- Shared pipeline package:
  - NOP_INSTR constant.
  - 32-bit word width constant.
  - if_entry typedef {pc[31:0], instr[31:0]}, reused by the decode stage.
- One natural sub-module, fq_ptr_ctrl: pointer/count/full/empty bookkeeping, with push, pop and flush in and wr_ptr, rd_ptr and count out.
- The top level holds storage and output muxing.

Test Plan:
- Reset mid-stream: 3 entries queued, assert reset asynchronously -> immediately count=0, out_valid=0, in_ready=1, out_instr=32'h0.
- Fill/drain: out_ready=0, push PCs 0x00, 0x04, 0x08, 0x0C -> count=4, in_ready=0, and a fifth push with PC 0x10 is not accepted. Then out_ready=1 -> outputs 0x00..0x0C in order, then out_valid=0.
- Wrap-around: 10 pushes and pops with out_ready toggling every cycle -> no loss or duplication, order preserved across pointer wrap, count never above 4.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> head popped, no push that cycle, count=3, in_ready=1 the next cycle.
- Flush priority: count=2, flush=1 together with push PC 0x40 and pop -> next cycle count=0, out_valid=0; the following push of PC 0x80 emerges as the next head.
- Bypass (FETCH_QUEUE_BYPASS_EN defined): empty, in_valid=1, in_pc=0x20, out_ready=1 -> same cycle out_valid=1, out_pc=0x20, count stays 0. With the macro undefined -> out_valid=0 that cycle, head appears the next cycle.
